// File: rtl/user_io_host.sv
// user_io_host: SPI master that sends command frames (cmd + 0..MAX_BYTES
// payload) to a user_io slave and captures the core-type byte returned
// on MISO during the command byte.
// Ports:
//   clk_sys, reset_n             clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_cmd, req_len, req_data   frame contents (byte 0 at [7:0], sent first)
//   busy, done                   frame in progress, one-cycle completion pulse
//   core_type, core_type_valid   byte captured during the command byte
//   SPI_SS_IO, SPI_CLK,
//   SPI_MOSI, SPI_MISO           SPI link, mode 0, MSB first
module user_io_host #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8,
  parameter int SS_GAP    = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_cmd,
  input  logic [3:0]             req_len,
  input  logic [8*MAX_BYTES-1:0] req_data,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             core_type,
  output logic                   core_type_valid,
  output logic                   SPI_SS_IO,
  output logic                   SPI_CLK,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam int W  = 8 * (MAX_BYTES + 1);
  localparam int BW = $clog2(W);
  localparam int CM = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CW = $clog2(CM) + 1;

  localparam logic [CW-1:0] D_LAST = CW'(CLK_DIV - 1);
  // GAP state plus the IDLE accept cycle make up SS_GAP high cycles
  // between back-to-back frames.
  localparam logic [CW-1:0] G_LAST = CW'(SS_GAP - 2);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOW  = 3'd1;
  localparam logic [2:0] HIGH = 3'd2;
  localparam logic [2:0] TAIL = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [BW-1:0] last_q, last_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [7:0]    ct_sh_q, ct_sh_d;
  logic [7:0]    core_type_q;
  logic          ctv_q;
  logic          done_q;
  logic          fin_d;

  logic [W-1:0]  frame;
  logic [BW-1:0] len_c;
  logic [BW-1:0] nlast;

  // Command byte in the top bits, payload byte 0 right below it.
  always_comb begin
    frame = '0;
    frame[W-1 -: 8] = req_cmd;
    for (int i = 0; i < MAX_BYTES; i++) begin
      frame[W-9-8*i -: 8] = req_data[8*i +: 8];
    end
  end

  always_comb begin
    len_c = BW'(req_len);
    if (BW'(req_len) > BW'(MAX_BYTES)) begin
      len_c = BW'(MAX_BYTES);
    end
    nlast = (len_c << 3) + BW'(7);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    last_d  = last_q;
    sh_d    = sh_q;
    ct_sh_d = ct_sh_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = '0;
          last_d  = nlast;
          sh_d    = frame;
        end
      end
      LOW: begin
        if (cnt_q == D_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0 && bit_q < BW'(8)) begin
          ct_sh_d = {ct_sh_q[6:0], SPI_MISO};
        end
        if (cnt_q == D_LAST) begin
          cnt_d = '0;
          if (bit_q == last_q) begin
            state_d = TAIL;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + BW'(1);
            sh_d    = {sh_q[W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TAIL: begin
        if (cnt_q == D_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == G_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered so done and core_type land on the last GAP cycle together.
  assign fin_d = (state_d == GAP) && (cnt_d == G_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      last_q      <= '0;
      sh_q        <= '0;
      ct_sh_q     <= '0;
      core_type_q <= '0;
      ctv_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      ct_sh_q <= ct_sh_d;
      done_q  <= fin_d;
      if (fin_d) begin
        core_type_q <= ct_sh_q;
        ctv_q       <= 1'b1;
      end
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign core_type       = core_type_q;
  assign core_type_valid = ctv_q;
  assign SPI_SS_IO       = ~((state_q == LOW) || (state_q == HIGH) ||
                             (state_q == TAIL));
  assign SPI_CLK         = (state_q == HIGH);
  assign SPI_MOSI        = ((state_q == LOW) || (state_q == HIGH)) ?
                           sh_q[W-1] : 1'b0;

endmodule

// File: tb/tb_user_io_host.sv
// tb_user_io_host: directed bench for user_io_host with an SPI slave
// model, wire-level byte scoreboard and a small user_io register model.
module tb_user_io_host;

  localparam int D = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = '0;
  logic [3:0]  req_len = '0;
  logic [63:0] req_data = '0;
  logic        busy, done;
  logic [7:0]  core_type;
  logic        core_type_valid;
  logic        SPI_SS_IO, SPI_CLK, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  user_io_host #(.CLK_DIV(D), .MAX_BYTES(8), .SS_GAP(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_len(req_len), .req_data(req_data),
    .busy(busy), .done(done),
    .core_type(core_type), .core_type_valid(core_type_valid),
    .SPI_SS_IO(SPI_SS_IO), .SPI_CLK(SPI_CLK),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 clk_sys = ~clk_sys;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_b[$];
  int exp_lo[$];
  int exp_rise[$];

  logic [7:0] slave_core = 8'h00;
  int rises = 0, bitc = 0, lo_cnt = 0, hi_cnt = 0;
  int last_gap = -1, done_cnt = 0, nrx = 0;
  bit prev_ss = 1'b1, prev_clk = 1'b0, seen = 1'b0;
  logic [7:0] cur = '0;
  logic [7:0] rx[16];

  logic [1:0]  m_buttons = '0, m_switches = '0;
  logic [3:0]  m_conf = '0;
  logic [15:0] m_joy0 = '0, m_joy1 = '0;

  task automatic push_exp(input logic [7:0] cmd, input logic [3:0] len,
                          input logic [63:0] data);
    int n;
    n = (len > 4'd8) ? 8 : int'(len);
    exp_b.push_back(cmd);
    for (int i = 0; i < n; i++) exp_b.push_back(data[8*i +: 8]);
    exp_lo.push_back(2*D*8*(n+1) + D);
    exp_rise.push_back(8*(n+1));
  endtask

  task automatic frame_end();
    chk("frame_expected", 32'(exp_lo.size() > 0), 1);
    if (exp_lo.size() > 0) begin
      chk("ss_low_cycles", lo_cnt, exp_lo.pop_front());
      chk("clk_rises", rises, exp_rise.pop_front());
    end
    if (nrx >= 2) begin
      case (rx[0])
        8'h01: {m_conf, m_switches, m_buttons} = rx[1];
        8'h60: m_joy0 = {8'h00, rx[1]};
        8'h61: m_joy1 = {8'h00, rx[1]};
        default: ;
      endcase
    end
  endtask

  // SPI slave / monitor, sampled on the falling system clock edge.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      exp_b.delete();
      exp_lo.delete();
      exp_rise.delete();
      rises = 0; bitc = 0; nrx = 0; lo_cnt = 0; hi_cnt = 0;
      prev_ss = 1'b1; prev_clk = 1'b0; seen = 1'b0;
      SPI_MISO = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (!SPI_SS_IO) begin
        if (prev_ss) begin
          if (seen) last_gap = hi_cnt;
          lo_cnt = 0; rises = 0; bitc = 0; nrx = 0;
        end
        lo_cnt++;
        if (SPI_CLK && !prev_clk) begin
          rises++;
          cur = {cur[6:0], SPI_MOSI};
          bitc++;
          if (bitc == 8) begin
            bitc = 0;
            if (nrx < 16) rx[nrx] = cur;
            nrx++;
            chk("rx_expected", 32'(exp_b.size() > 0), 1);
            if (exp_b.size() > 0) chk("rx_byte", cur, exp_b.pop_front());
          end
        end
        if (!SPI_CLK)
          SPI_MISO = (rises < 8) ? slave_core[3'(7 - rises)] : 1'b0;
      end else begin
        if (!prev_ss) begin
          hi_cnt = 0;
          seen = 1'b1;
          frame_end();
        end
        hi_cnt++;
        SPI_MISO = 1'b0;
      end
      prev_ss = SPI_SS_IO;
      prev_clk = SPI_CLK;
    end
  end

  task automatic send(input logic [7:0] cmd, input logic [3:0] len,
                      input logic [63:0] data, input logic [7:0] core,
                      input bit hold);
    push_exp(cmd, len, data);
    slave_core = core;
    req_cmd = cmd;
    req_len = len;
    req_data = data;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (busy) break;
    end
    chk("accepted", busy, 1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [7:0] exp_core);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (done) break;
    end
    chk("done_seen", done, 1);
    chk("core_type", core_type, exp_core);
    chk("core_valid", core_type_valid, 1);
    @(negedge clk_sys);
    chk("done_pulse", done, 0);
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ss", SPI_SS_IO, 1);
    chk("rst_clk", SPI_CLK, 0);
    chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core", core_type, 8'h00);
    chk("rst_cvalid", core_type_valid, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_ready", req_ready, 1);

    // 1: buttons/switches frame
    send(8'h01, 4'd1, 64'hA3, 8'h5C, 1'b0);
    wait_done(8'h5C);
    chk("t1_buttons", m_buttons, 2'b11);
    chk("t1_switches", m_switches, 2'b00);
    chk("t1_conf", m_conf, 4'hA);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: keyboard/mouse frame, 4 payload bytes
    send(8'h70, 4'd4, 64'h00_01_FB_05, 8'h3C, 1'b0);
    wait_done(8'h3C);

    // 3: command only, core type A5
    send(8'h05, 4'd0, 64'h0, 8'hA5, 1'b0);
    wait_done(8'hA5);

    // 4: back-to-back with req_valid held
    send(8'h60, 4'd1, 64'h10, 8'h11, 1'b1);
    push_exp(8'h61, 4'd1, 64'h08);
    req_cmd = 8'h61;
    req_data = 64'h08;
    wait_done(8'h11);
    @(negedge clk_sys);
    chk("b2b_accept", busy, 1);
    req_valid = 1'b0;
    wait_done(8'h11);
    chk("b2b_gap", last_gap, 4);
    chk("joy0", m_joy0, 16'h0010);
    chk("joy1", m_joy1, 16'h0008);

    // 5: reset in the middle of payload byte 0
    send(8'h62, 4'd2, 64'h55AA, 8'h77, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_sys);
      if (rises >= 11) break;
    end
    chk("reach_bit", 32'(rises >= 11), 1);
    d0 = done_cnt;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_ss", SPI_SS_IO, 1);
    chk("mid_rst_clk", SPI_CLK, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("mid_rst_nodone", done_cnt, d0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_cvalid", core_type_valid, 0);
    chk("mid_rst_core", core_type, 8'h00);
    send(8'h05, 4'd2, 64'hC3_3C, 8'h96, 1'b0);
    wait_done(8'h96);

    // 6: length clamp and request while busy
    send(8'h63, 4'd12, 64'h08_07_06_05_04_03_02_01, 8'hE1, 1'b0);
    repeat (30) @(negedge clk_sys);
    req_cmd = 8'h99;
    req_len = 4'd0;
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk_sys);
      chk("busy_not_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    wait_done(8'hE1);
    repeat (20) @(negedge clk_sys);
    chk("no_extra_frame", SPI_SS_IO, 1);
    chk("sb_empty", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
